// File: rtl/lab_nios_system_led_pio_blink.sv
// Avalon-MM LED output PIO with atomic SET/CLEAR/TOGGLE and per-bit hardware blink.
// Optional PWM brightness (BRIGHT register, addr 6) is built when LED_PIO_PWM_EN is defined.
module lab_nios_system_led_pio_blink #(
  parameter int               WIDTH        = 9,
  parameter int               PRESCALE_DIV = 50000,
  parameter int               PERIOD_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_BLINK  = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_SET    = 3'd3;
  localparam logic [2:0] A_CLEAR  = 3'd4;
  localparam logic [2:0] A_TOGGLE = 3'd5;
  localparam logic [2:0] A_BRIGHT = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    blink;
  logic [PERIOD_W-1:0] period;
  logic                phase;
  logic [PRE_W-1:0]    pre_cnt;
  logic [PERIOD_W-1:0] per_cnt;
  logic                wr;
  logic                period_wr;
  logic                tick;
  logic [WIDTH-1:0]    wd;
  logic [WIDTH-1:0]    out_nxt;
  logic                unused_bits;

  assign wr          = chipselect && !write_n;
  assign period_wr   = wr && (address == A_PERIOD);
  assign tick        = (pre_cnt == PRE_LAST);
  assign wd          = writedata[WIDTH-1:0];
  assign unused_bits = &{1'b0, writedata};

  always_ff @(posedge clk) begin
    if (reset) begin
      data   <= RESET_VALUE;
      blink  <= '0;
      period <= '0;
    end else if (wr) begin
      case (address)
        A_DATA:   data   <= wd;
        A_BLINK:  blink  <= wd;
        A_PERIOD: period <= writedata[PERIOD_W-1:0];
        A_SET:    data   <= data | wd;
        A_CLEAR:  data   <= data & ~wd;
        A_TOGGLE: data   <= data ^ wd;
        default:  ;
      endcase
    end
  end

  // A PERIOD write restarts the blink in phase 1 and wins over any coincident tick or flip.
  always_ff @(posedge clk) begin
    if (reset || period_wr) begin
      pre_cnt <= '0;
      per_cnt <= '0;
      phase   <= 1'b1;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (period == '0) begin
        per_cnt <= '0;
        phase   <= 1'b1;
      end else if (tick) begin
        if (per_cnt == period - PERIOD_W'(1)) begin
          per_cnt <= '0;
          phase   <= ~phase;
        end else begin
          per_cnt <= per_cnt + PERIOD_W'(1);
        end
      end
    end
  end

`ifdef LED_PIO_PWM_EN
  logic [7:0] bright;
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      bright  <= 8'hFF;
      pwm_cnt <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr && (address == A_BRIGHT)) bright <= writedata[7:0];
    end
  end

  // 0xFF means fully on, so the compare alone would leave one dark slot per 256.
  assign pwm_on  = (pwm_cnt < bright) || (bright == 8'hFF);
  assign out_nxt = data & (~blink | {WIDTH{phase}}) & {WIDTH{pwm_on}};
`else
  assign out_nxt = data & (~blink | {WIDTH{phase}});
`endif

  always_ff @(posedge clk) begin
    if (reset) out_port <= RESET_VALUE;
    else       out_port <= out_nxt;
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0]    = data;
      A_BLINK:  readdata[WIDTH-1:0]    = blink;
      A_PERIOD: readdata[PERIOD_W-1:0] = period;
`ifdef LED_PIO_PWM_EN
      A_BRIGHT: readdata[7:0]          = bright;
`endif
      A_STATUS: readdata[1:0]          = {tick, phase};
      default:  readdata               = '0;
    endcase
  end

endmodule

// File: tb/tb_lab_nios_system_led_pio_blink.sv
// Directed bench for lab_nios_system_led_pio_blink (WIDTH=9, PRESCALE_DIV=4, RESET_VALUE=9'h0A5).
module tb_lab_nios_system_led_pio_blink;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [8:0]  out_port;

  int vectors     = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  lab_nios_system_led_pio_blink #(
    .WIDTH        (9),
    .PRESCALE_DIV (4),
    .PERIOD_W     (16),
    .RESET_VALUE  (9'h0A5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic out_is(input logic [31:0] exp, input string tag);
    chk(tag, {23'd0, out_port}, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  initial begin
    int on_cnt;
    int bad_cnt;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;

    // Reset
    step(1);
    out_is(32'h0A5, "rst_out");
    rd(3'd0, 32'h0000_00A5, "rst_data");
    rd(3'd1, 32'h0, "rst_blink");
    rd(3'd2, 32'h0, "rst_period");
    rd(3'd7, 32'h1, "rst_status");
    step(1);
    reset = 1'b0;
    step(1);
    out_is(32'h0A5, "post_rst_out");

    // Atomics
    wr(3'd0, 32'h0F0);
    rd(3'd0, 32'h0F0, "data_wr");
    step(1);
    out_is(32'h0F0, "out_data_wr");
    wr(3'd3, 32'h003);
    rd(3'd0, 32'h0F3, "data_set");
    rd(3'd3, 32'h0, "rd_set_zero");
    step(1);
    out_is(32'h0F3, "out_set");
    wr(3'd4, 32'h030);
    rd(3'd0, 32'h0C3, "data_clear");
    rd(3'd4, 32'h0, "rd_clear_zero");
    step(1);
    out_is(32'h0C3, "out_clear");
    wr(3'd5, 32'h101);
    rd(3'd0, 32'h1C2, "data_toggle");
    rd(3'd5, 32'h0, "rd_toggle_zero");
    step(1);
    out_is(32'h1C2, "out_toggle");

    // Blink, PERIOD=3: phase flips every 12 clk, pin follows 1 clk later
    wr(3'd0, 32'h1FF);
    wr(3'd1, 32'h00F);
    wr(3'd2, 32'h3);
    rd(3'd2, 32'h3, "period_rd");
    step(10);
    step(1);
    out_is(32'h1FF, "blink_w11_out");
    rd(3'd7, 32'h3, "blink_w11_status");
    step(1);
    rd(3'd7, 32'h0, "blink_w12_status");
    out_is(32'h1FF, "blink_w12_out");
    step(1);
    out_is(32'h1F0, "blink_w13_out");
    step(11);
    out_is(32'h1F0, "blink_w24_out");
    rd(3'd7, 32'h1, "blink_w24_status");
    step(1);
    out_is(32'h1FF, "blink_w25_out");

    // PERIOD write coincident with the flip at W+36
    step(10);
    wr(3'd2, 32'h2);
    rd(3'd7, 32'h1, "restart_no_flip");
    out_is(32'h1FF, "restart_out0");
    step(1);
    out_is(32'h1FF, "restart_out1");
    step(6);
    rd(3'd7, 32'h3, "restart_w7_status");
    step(1);
    rd(3'd7, 32'h0, "restart_w8_status");
    step(1);
    out_is(32'h1F0, "restart_w9_out");

    // Halt mid-low-phase
    wr(3'd2, 32'h0);
    out_is(32'h1F0, "halt_out0");
    rd(3'd7, 32'h1, "halt_status");
    step(1);
    out_is(32'h1FF, "halt_out1");
    step(20);
    out_is(32'h1FF, "halt_out_hold");
    rd(3'd2, 32'h0, "halt_period_rd");
    rd(3'd7, 32'h1, "halt_status_hold");

    // Reset mid-blink
    wr(3'd2, 32'h1);
    step(5);
    out_is(32'h1F0, "pre_reset_low");
    reset = 1'b1;
    step(1);
    out_is(32'h0A5, "midrst_out");
    rd(3'd0, 32'h0A5, "midrst_data");
    rd(3'd1, 32'h0, "midrst_blink");
    rd(3'd2, 32'h0, "midrst_period");
    rd(3'd7, 32'h1, "midrst_status");
    reset = 1'b0;
    step(8);
    out_is(32'h0A5, "postrst_hold");

    // STATUS is read-only
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd0, 32'h0A5, "status_wr_data");
    rd(3'd1, 32'h0, "status_wr_blink");

`ifdef LED_PIO_PWM_EN
    rd(3'd6, 32'hFF, "bright_rst");
    wr(3'd0, 32'h1FF);
    wr(3'd6, 32'h40);
    rd(3'd6, 32'h40, "bright_rd");
    step(2);
    on_cnt  = 0;
    bad_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (out_port == 9'h1FF) on_cnt++;
      else if (out_port != 9'h000) bad_cnt++;
      step(1);
    end
    chk("pwm_on_count", on_cnt, 64);
    chk("pwm_bad_levels", bad_cnt, 0);
    wr(3'd6, 32'h00);
    step(1);
    bad_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (out_port != 9'h000) bad_cnt++;
      step(1);
    end
    chk("pwm_bright0", bad_cnt, 0);
    wr(3'd6, 32'hFF);
    step(1);
    bad_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (out_port != 9'h1FF) bad_cnt++;
      step(1);
    end
    chk("pwm_brightff", bad_cnt, 0);
`else
    on_cnt  = 0;
    bad_cnt = 0;
    wr(3'd6, 32'h40);
    rd(3'd6, 32'h0, "bright_absent_rd");
    step(1);
    out_is(32'h0A5, "bright_absent_out");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
